// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch read
// port (if_*) and a data load/store port (dm_*). One transaction at a time:
// IDLE samples requests, ACCESS drives the memory port for MEM_LATENCY
// cycles (mem_en only in the first), DONE pulses the granted port's ack.
//
// Parameter:
//   MEM_LATENCY  cycles from mem_en to valid mem_rdata (1..15)
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             fetch request in; if_ack/if_rdata out
//   dm_req/dm_we/dm_addr/dm_wdata  data request in; dm_ack/dm_rdata out
//   mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in: shared memory port
//   busy                       high whenever a transaction is in flight
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN     defined: alternate on contention (dm first
//                              after reset); undefined: dm always wins.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_dm_q;
  logic             we_q;
  logic             if_ack_q, dm_ack_q;
  logic [31:0]      if_rdata_q, dm_rdata_q;
  logic             mem_en_q, mem_we_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic             busy_q;
  logic             pick_dm_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic             last_gnt_dm_q;
`endif

  // Grant selection for the current IDLE cycle
  always_comb begin
    pick_dm_c = 1'b0;
    if (dm_req && !if_req) begin
      pick_dm_c = 1'b1;
    end else if (dm_req && if_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_dm_c = !last_gnt_dm_q;
`else
      pick_dm_c = 1'b1;
`endif
    end
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_dm_q    <= 1'b0;
      we_q        <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_gnt_dm_q <= 1'b0;
`endif
    end else begin
      // single-cycle strobes default low
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || dm_req) begin
            state_q     <= ACCESS;
            cnt_q       <= CNT_W'(1);
            busy_q      <= 1'b1;
            gnt_dm_q    <= pick_dm_c;
            we_q        <= pick_dm_c && dm_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= pick_dm_c && dm_we;
            mem_addr_q  <= pick_dm_c ? dm_addr : if_addr;
            mem_wdata_q <= pick_dm_c ? dm_wdata : 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_gnt_dm_q <= pick_dm_c;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == LAT) begin
            // memory data is valid in this cycle; writes leave dm_rdata alone
            if (!gnt_dm_q) begin
              if_rdata_q <= mem_rdata;
            end else if (!we_q) begin
              dm_rdata_q <= mem_rdata;
            end
            if_ack_q    <= !gnt_dm_q;
            dm_ack_q    <= gnt_dm_q;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (MEM_LATENCY=2): a transaction-level model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // transaction model: one outstanding grant, described by its grant cycle
  bit          m_active = 1'b0;
  int          m_g      = 0;
  bit          m_dm     = 1'b0;
  bit          m_we     = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [31:0] m_if_rd  = '0;
  logic [31:0] m_dm_rd  = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit          m_last_dm = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance it by one edge
  task automatic model_step();
    int k;
    logic e_en, e_we, e_busy, e_ifa, e_dma, pick;
    logic [31:0] e_addr, e_wd;
    k = cyc - m_g;
    e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_ifa = 1'b0; e_dma = 1'b0;
    e_addr = '0; e_wd = '0;
    if (m_active) begin
      e_busy = 1'b1;
      e_en   = (k == 1);
      e_we   = (k == 1) && m_we;
      if (k <= L) begin
        e_addr = m_addr;
        e_wd   = m_wdata;
      end
      e_ifa = (k == L + 1) && !m_dm;
      e_dma = (k == L + 1) && m_dm;
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("if_ack", 32'(if_ack), 32'(e_ifa));
    chk("dm_ack", 32'(dm_ack), 32'(e_dma));
    chk("if_rdata", if_rdata, m_if_rd);
    chk("dm_rdata", dm_rdata, m_dm_rd);

    if (reset) begin
      m_active = 1'b0;
      m_if_rd  = '0;
      m_dm_rd  = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_last_dm = 1'b0;
`endif
    end else if (m_active) begin
      if (k == L) begin
        if (!m_dm) m_if_rd = mem_rdata;
        else if (!m_we) m_dm_rd = mem_rdata;
      end
      if (k == L + 1) m_active = 1'b0;
    end else if (if_req || dm_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick = (if_req && dm_req) ? !m_last_dm : dm_req;
      m_last_dm = pick;
`else
      pick = dm_req;
`endif
      m_active = 1'b1;
      m_g      = cyc;
      m_dm     = pick;
      m_we     = pick && dm_we;
      m_addr   = pick ? dm_addr : if_addr;
      m_wdata  = pick ? dm_wdata : 32'h0;
    end
  endtask

  // Check the ending cycle, then move to the start of the next one
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic exp_dm;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    reset = 1'b0;
    tick();

    // fetch read, req dropped right after grant
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    chk("A_c1_mem_en", 32'(mem_en), 32'h1);
    chk("A_c1_addr", mem_addr, 32'h0000_0040);
    chk("A_c1_busy", 32'(busy), 32'h1);
    if_req = 1'b0; mem_rdata = 32'h1111_1111;
    tick();
    chk("A_c2_mem_en", 32'(mem_en), 32'h0);
    mem_rdata = 32'h8C22_0004;
    tick();
    chk("A_c3_if_ack", 32'(if_ack), 32'h1);
    chk("A_c3_if_rdata", if_rdata, 32'h8C22_0004);
    chk("A_c3_busy", 32'(busy), 32'h1);
    mem_rdata = 32'h2222_2222;
    tick();
    chk("A_c4_if_ack", 32'(if_ack), 32'h0);
    chk("A_c4_busy", 32'(busy), 32'h0);
    chk("A_c4_if_rdata", if_rdata, 32'h8C22_0004);

    // data read
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200;
    tick();
    dm_req = 1'b0;
    tick();
    mem_rdata = 32'hA5A5_0F0F;
    tick();
    chk("B_c3_dm_ack", 32'(dm_ack), 32'h1);
    chk("B_c3_dm_rdata", dm_rdata, 32'hA5A5_0F0F);
    tick();

    // data write leaves dm_rdata untouched
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk("C_c1_mem_we", 32'(mem_we), 32'h1);
    chk("C_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("C_c1_addr", mem_addr, 32'h0000_0100);
    dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'h3333_3333;
    tick();
    chk("C_c2_mem_we", 32'(mem_we), 32'h0);
    chk("C_c2_addr", mem_addr, 32'h0000_0100);
    tick();
    chk("C_c3_dm_ack", 32'(dm_ack), 32'h1);
    chk("C_c3_dm_rdata", dm_rdata, 32'hA5A5_0F0F);
    tick();
    chk("C_c4_addr", mem_addr, 32'h0);

    // unaligned address passes through
    if_req = 1'b1; if_addr = 32'hFFFF_FFFD;
    tick();
    if_req = 1'b0;
    tick();
    mem_rdata = 32'h0BAD_F00D;
    tick(); tick();

    // contention, dm releases after its ack
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    dm_req = 1'b1; dm_addr = 32'h0000_0020; mem_rdata = 32'h5555_AAAA;
    tick(); tick(); tick();
    chk("E_c3_dm_ack", 32'(dm_ack), 32'h1);
    chk("E_c3_if_ack", 32'(if_ack), 32'h0);
    dm_req = 1'b0;
    tick();
    chk("E_c4_busy", 32'(busy), 32'h0);
    tick();
    chk("E_c5_mem_addr", mem_addr, 32'h0000_0010);
    tick(); tick();
    chk("E_c7_if_ack", 32'(if_ack), 32'h1);
    if_req = 1'b0;
    tick();

    // both held continuously
    do_reset();
    if_req = 1'b1; dm_req = 1'b1; mem_rdata = 32'h7777_0001;
    for (int k = 1; k <= 16; k++) begin
      tick();
      mem_rdata = mem_rdata + 32'h1;
      if (k % 4 == 3) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_dm = ((k / 4) % 2) == 0;
`else
        exp_dm = 1'b1;
`endif
        chk("F_dm_ack", 32'(dm_ack), 32'(exp_dm));
        chk("F_if_ack", 32'(if_ack), 32'(!exp_dm));
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick(); tick(); tick();

    // reset mid-read abandons the transaction
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
    tick();
    dm_req = 1'b0;
    tick();
    reset = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    reset = 1'b0;
    chk("G_c3_busy", 32'(busy), 32'h0);
    chk("G_c3_dm_ack", 32'(dm_ack), 32'h0);
    chk("G_c3_dm_rdata", dm_rdata, 32'h0);
    tick();
    chk("G_c4_dm_ack", 32'(dm_ack), 32'h0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
